// File: rtl/sierpinski_pattern_gen.sv
// Pattern generator: Fibonacci LFSR, rule-90 and rule-150 cellular automata
// on a WIDTH-bit state register. Includes a step prescaler, row/frame
// counting with optional reseed at frame wrap, and zero-state recovery.
module sierpinski_pattern_gen #(
   parameter int               WIDTH           = 8,
   parameter logic [WIDTH-1:0] TAPS            = 8'hB8,
   parameter logic [WIDTH-1:0] SEED_DEFAULT    = 8'h01,
   parameter int               DIV_W           = 8,
   parameter int               ROWS            = 8,
   parameter int               ROW_W           = 4,
   parameter bit               RESEED_ON_FRAME = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [1:0]       mode,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic [DIV_W-1:0] div,
   output logic [WIDTH-1:0] state_out,
   output logic             step_pulse,
   output logic [ROW_W-1:0] row_count,
   output logic             frame_done,
   output logic             lockup
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             step_q, step_d;
   logic             frame_q, frame_d;
   logic             lock_q, lock_d;

   // One generation of the selected pattern; out-of-range neighbours read 0
   // because the shifts fill with zeros.
   function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] s,
                                                input logic [1:0]       m);
      logic [WIDTH-1:0] n;
      case (m)
         2'b00:   n = {s[WIDTH-2:0], ^(s & TAPS)};
         2'b01:   n = (s << 1) ^ (s >> 1);
         2'b10:   n = (s << 1) ^ s ^ (s >> 1);
         default: n = s;
      endcase
      return n;
   endfunction

   logic             run;
   logic             due;
   logic [WIDTH-1:0] cand;

   assign run = ena && (mode != 2'b11);
   // >= rather than == so that lowering div never strands the prescaler
   // above the new terminal count.
   assign due = run && (presc_q >= div);

   // Next-state: seed load beats everything, then step/prescaler advance.
   always_comb begin
      state_d    = state_q;
      seed_reg_d = seed_reg_q;
      presc_d    = presc_q;
      row_d      = row_q;
      step_d     = 1'b0;
      frame_d    = 1'b0;
      lock_d     = 1'b0;
      cand       = step_fn(state_q, mode);
      if (seed_load) begin
         if (seed == '0) begin
            state_d    = SEED_DEFAULT;
            seed_reg_d = SEED_DEFAULT;
            lock_d     = 1'b1;
         end else begin
            state_d    = seed;
            seed_reg_d = seed;
         end
         presc_d = '0;
         row_d   = '0;
      end else if (due) begin
         presc_d = '0;
         step_d  = 1'b1;
         if (row_q == LAST_ROW) begin
            row_d   = '0;
            frame_d = 1'b1;
            if (RESEED_ON_FRAME) cand = seed_reg_q;
         end else begin
            row_d = row_q + ROW_W'(1);
         end
         if (cand == '0) begin
            state_d = SEED_DEFAULT;
            lock_d  = 1'b1;
         end else begin
            state_d = cand;
         end
      end else if (run) begin
         presc_d = presc_q + DIV_W'(1);
      end
   end

   // State and pulse registers, asynchronously returned to defaults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEED_DEFAULT;
         seed_reg_q <= SEED_DEFAULT;
         presc_q    <= '0;
         row_q      <= '0;
         step_q     <= 1'b0;
         frame_q    <= 1'b0;
         lock_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seed_reg_q <= seed_reg_d;
         presc_q    <= presc_d;
         row_q      <= row_d;
         step_q     <= step_d;
         frame_q    <= frame_d;
         lock_q     <= lock_d;
      end
   end

   assign state_out  = state_q;
   assign step_pulse = step_q;
   assign row_count  = row_q;
   assign frame_done = frame_q;
   assign lockup     = lock_q;

endmodule

// File: tb/tb_sierpinski_pattern_gen.sv
// Directed bench for sierpinski_pattern_gen: a default instance (reseed on
// frame) and a second instance without reseed share the same stimulus.
module tb_sierpinski_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [1:0] mode;
   logic       seed_load;
   logic [7:0] seed;
   logic [7:0] div;

   logic [7:0] state_out, nr_state;
   logic       step_pulse, nr_step;
   logic [3:0] row_count, nr_row;
   logic       frame_done, nr_frame;
   logic       lockup, nr_lock;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   sierpinski_pattern_gen dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
      .seed_load(seed_load), .seed(seed), .div(div),
      .state_out(state_out), .step_pulse(step_pulse), .row_count(row_count),
      .frame_done(frame_done), .lockup(lockup)
   );

   sierpinski_pattern_gen #(.RESEED_ON_FRAME(1'b0)) dut_nr (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
      .seed_load(seed_load), .seed(seed), .div(div),
      .state_out(nr_state), .step_pulse(nr_step), .row_count(nr_row),
      .frame_done(nr_frame), .lockup(nr_lock)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  r90 [8];
      logic [255:0] seen;
      logic [11:0] pv;
      logic [7:0]  snap;
      logic [3:0]  row_snap;
      int          zeros, reps, first_ret, pulses, changes;

      r90[0] = 8'h28; r90[1] = 8'h44; r90[2] = 8'hAA; r90[3] = 8'h01;
      r90[4] = 8'h02; r90[5] = 8'h05; r90[6] = 8'h08; r90[7] = 8'h10;

      rst_n = 1'b0; ena = 1'b0; mode = 2'b00; seed_load = 1'b0;
      seed = 8'h00; div = 8'h00;
      repeat (3) tick();
      check_val("rst_state", 32'(state_out), 32'h01);
      check_val("rst_row",   32'(row_count), 32'h0);
      check_val("rst_step",  32'(step_pulse), 32'h0);
      check_val("rst_frame", 32'(frame_done), 32'h0);
      check_val("rst_lock",  32'(lockup), 32'h0);
      rst_n = 1'b1;
      tick();

      // Rule 90 from 0x10, frame wrap after the 8th step
      ena = 1'b1; mode = 2'b01; div = 8'd0; seed = 8'h10; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      check_val("r90_load_state", 32'(state_out), 32'h10);
      check_val("r90_load_step",  32'(step_pulse), 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_val($sformatf("r90_state_%0d", i), 32'(state_out), 32'(r90[i]));
         check_val($sformatf("r90_step_%0d", i), 32'(step_pulse), 32'h1);
         check_val($sformatf("r90_row_%0d", i), 32'(row_count), (i == 7) ? 32'h0 : 32'(i + 1));
         check_val($sformatf("r90_frame_%0d", i), 32'(frame_done), (i == 7) ? 32'h1 : 32'h0);
      end
      check_val("nr_wrap_state", 32'(nr_state), 32'h14);
      check_val("nr_wrap_frame", 32'(nr_frame), 32'h1);
      check_val("nr_wrap_row",   32'(nr_row), 32'h0);
      tick();
      check_val("r90_after_frame", 32'(frame_done), 32'h0);
      check_val("r90_after_state", 32'(state_out), 32'h28);

      // Asynchronous reset at row 5
      seed = 8'h10; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      repeat (5) tick();
      check_val("mid_row5", 32'(row_count), 32'h5);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_state", 32'(state_out), 32'h01);
      check_val("mid_rst_row",   32'(row_count), 32'h0);
      check_val("mid_rst_step",  32'(step_pulse), 32'h0);
      tick();
      rst_n = 1'b1;

      // LFSR period on the non-reseeding instance
      mode = 2'b00; seed = 8'h01; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      seen = '0; seen[1] = 1'b1;
      zeros = 0; reps = 0; first_ret = 0;
      for (int k = 1; k <= 255; k++) begin
         tick();
         if (k == 4) check_val("lfsr_step4", 32'(nr_state), 32'h11);
         if (nr_state == 8'h00) zeros++;
         if (nr_state == 8'h01 && first_ret == 0) first_ret = k;
         if (k < 255 && seen[nr_state]) reps++;
         seen[nr_state] = 1'b1;
      end
      check_val("lfsr_first_return", 32'(first_ret), 32'd255);
      check_val("lfsr_zeros", 32'(zeros), 32'd0);
      check_val("lfsr_repeats", 32'(reps), 32'd0);

      // Prescaler div=3, enable freeze, div lowered mid-count
      mode = 2'b01; div = 8'd3; seed = 8'h10; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         pv[i] = step_pulse;
      end
      check_val("div3_pulses", 32'(pv), 32'h888);
      check_val("div3_state",  32'(state_out), 32'hAA);
      check_val("div3_row",    32'(row_count), 32'h3);
      repeat (2) tick();
      ena = 1'b0;
      pulses = 0; changes = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (step_pulse) pulses++;
         if (state_out != 8'hAA) changes++;
      end
      check_val("ena0_pulses", 32'(pulses), 32'd0);
      check_val("ena0_changes", 32'(changes), 32'd0);
      ena = 1'b1;
      tick();
      check_val("ena1_presc3", 32'(step_pulse), 32'h0);
      tick();
      check_val("ena1_step", 32'(step_pulse), 32'h1);
      check_val("ena1_state", 32'(state_out), 32'h01);
      repeat (2) tick();
      check_val("presc2_nostep", 32'(step_pulse), 32'h0);
      div = 8'd0;
      tick();
      check_val("divdrop_step",  32'(step_pulse), 32'h1);
      check_val("divdrop_state", 32'(state_out), 32'h02);
      check_val("divdrop_row",   32'(row_count), 32'h5);

      // Zero seed, seed-vs-step priority, rule-150 lockup
      seed = 8'h00; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      check_val("zseed_state", 32'(state_out), 32'h01);
      check_val("zseed_lock",  32'(lockup), 32'h1);
      check_val("zseed_step",  32'(step_pulse), 32'h0);
      check_val("zseed_row",   32'(row_count), 32'h0);
      tick();
      check_val("zseed_lock_clr", 32'(lockup), 32'h0);
      check_val("zseed_next",     32'(state_out), 32'h02);
      seed = 8'h40; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      check_val("prio_state", 32'(state_out), 32'h40);
      check_val("prio_row",   32'(row_count), 32'h0);
      check_val("prio_step",  32'(step_pulse), 32'h0);
      mode = 2'b10; seed = 8'hDB; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      tick();
      check_val("r150_lock_state", 32'(state_out), 32'h01);
      check_val("r150_lock_pulse", 32'(lockup), 32'h1);
      check_val("r150_lock_step",  32'(step_pulse), 32'h1);

      // Freeze in mode 11, then rule 150 from 0x10
      mode = 2'b11; seed = 8'h10; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      check_val("frz_load", 32'(state_out), 32'h10);
      snap = state_out; row_snap = row_count;
      pulses = 0; changes = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (step_pulse || frame_done || lockup) pulses++;
         if (state_out != snap || row_count != row_snap) changes++;
      end
      check_val("frz_pulses", 32'(pulses), 32'd0);
      check_val("frz_changes", 32'(changes), 32'd0);
      mode = 2'b10;
      tick();
      check_val("r150_state", 32'(state_out), 32'h38);
      check_val("r150_step",  32'(step_pulse), 32'h1);
      check_val("r150_row",   32'(row_count), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/sierpinski_pattern_gen.md
Name: sierpinski_pattern_gen

Overview:
Parametrised successor to the fixed 8-bit Sierpinski/LFSR pattern core. It generates one of several per-step bit patterns on a WIDTH-bit state register:
- Fibonacci LFSR
- rule-90 cellular automaton (Sierpinski triangle)
- rule-150 cellular automaton

Adds seed loading, a programmable step prescaler, row/frame counting with optional reseed, and zero-state lockup recovery. It sits behind the tile wrapper, with state_out driven toward uo_out.

Parameters:
WIDTH, 8, state/pattern width (>=4)
TAPS, 8'hB8, LFSR feedback mask, WIDTH bits
SEED_DEFAULT, 8'h01, reset/recovery seed, nonzero, WIDTH bits
DIV_W, 8, prescaler width
ROWS, 8, steps per frame (2..2^ROW_W)
ROW_W, 4, row counter width
RESEED_ON_FRAME, 1, 1 = reload seed_reg at frame wrap

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  run enable; low freezes prescaler and state
mode  in  2  00 LFSR, 01 rule 90, 10 rule 150, 11 freeze
seed_load  in  1  one-cycle load request
seed  in  WIDTH  value captured on seed_load
div  in  DIV_W  step every div+1 enabled cycles
state_out  out  WIDTH  current pattern register
step_pulse  out  1  high for the one cycle in which a new stepped state is first visible
row_count  out  ROW_W  steps since frame start
frame_done  out  1  one-cycle pulse on frame wrap
lockup  out  1  one-cycle pulse when zero state replaced by SEED_DEFAULT

Behaviour:
- Reset (async assert, sync release): state=SEED_DEFAULT, seed_reg=SEED_DEFAULT, prescaler=0, row_count=0, step_pulse=frame_done=lockup=0.
- Asserting reset mid-operation returns all registers to reset values immediately.
- All outputs are registered.
- Prescaler:
  - Advances only when ena=1 and mode!=11.
  - When prescaler>=div: that edge clears prescaler and performs a step. Using >= prevents a long wait after div is lowered.
  - Otherwise prescaler+1.
  - div=0 gives a step every enabled cycle.
- Step function (next-state computation N from s):
  - LFSR: N={s[WIDTH-2:0], ^(s&TAPS)}. Defaults give period 255 over nonzero states.
  - Rule 90: N[i]=s[i-1]^s[i+1].
  - Rule 150: N[i]=s[i-1]^s[i]^s[i+1].
  - Null boundaries: out-of-range bits read 0.
- Step edge:
  - step_pulse=1.
  - If row_count==ROWS-1: row_count=0, frame_done=1, and state=seed_reg when RESEED_ON_FRAME=1, else N.
  - Otherwise row_count+1, state=N.
- Lockup recovery: if the value to be written on a step is all-zero, write SEED_DEFAULT instead and pulse lockup in the same cycle as step_pulse.
- seed_load:
  - Highest priority; acts regardless of ena and mode.
  - state=seed and seed_reg=seed; prescaler=0, row_count=0; no step_pulse or frame_done.
  - If seed==0: load SEED_DEFAULT into both and pulse lockup.
- Mode change: takes effect at the next step. Prescaler and row_count are not reset.
- Mode 11: state, prescaler and row_count hold; no pulses.
- Pulses deassert the cycle after assertion unless re-triggered.

Test Plan:
- Reset (defaults): hold rst_n=0 -> state_out=8'h01, row_count=0, all pulses 0; assert rst_n mid-run at row 5 -> immediate return to same values.
- Rule-90 sequence (mode 01, div 0, seed_load 8'h10): successive step_pulses show 8'h28, 8'h44, 8'hAA. After the 8th step: frame_done=1, state_out=8'h10, row_count=0.
- LFSR period (RESEED_ON_FRAME=0, mode 00, div 0, seed 8'h01): state first returns to 8'h01 after exactly 255 steps, with no zero and no repeated state.
- Prescaler and enable (div=3): step_pulse every 4th cycle. ena=0 for 5 cycles -> no pulses, state and prescaler frozen. Lower div 3->0 while prescaler=2 -> step on the next cycle.
- Lockup/seed priority:
  - seed_load with 8'h00 -> state_out=8'h01, lockup=1 for one cycle, no step_pulse.
  - seed_load coincident with a due step -> loaded seed wins, row_count=0.
- Freeze and mode switch: mode 11 for 10 cycles -> no state change. Switch rule 90 -> rule 150 from 8'h10 -> next step gives 8'h38.
